quad_angle_encoder: RTL and testbench
=====================================

# quad_angle_encoder

Quadrature encoder front end producing the 32-bit angle word consumed by the angle PIO input port of the HPS-visible `soc_system`. It sits directly upstream of that PIO, whose `in_port` it drives. It synchronises and filters the A/B/I encoder pins and decodes them 4x into a position count and a signed revolution count. The result is a single registered word that software samples through the PIO read.

## Interface
Parameters:
- `COUNTS_PER_REV`, default 8192: 4x counts per mechanical revolution. Legal range 2..65536.
- `SYNC_STAGES`, default 2: synchroniser depth per pin. Minimum 2.
- `FILTER_LEN`, default 4: consecutive stable cycles needed before a synchronised level is accepted. Minimum 1.

Ports:
- `clk`, input, 1: system clock. This is the same clock as the PIO.
- `reset`, input, 1: asynchronous, active-high reset.
- `enc_a`, input, 1: encoder channel A, asynchronous pin.
- `enc_b`, input, 1: encoder channel B, asynchronous pin.
- `enc_i`, input, 1: encoder index pulse, asynchronous pin.
- `clear`, input, 1: synchronous one-cycle command that zeroes position, revolutions and error.
- `angle_out`, output, 32: `{rev[15:0], pos[15:0]}`. This is the PIO `in_port` data.
- `err`, output, 1: sticky illegal-transition flag.

## Operation
- **Per-pin filter.** Each pin passes through `SYNC_STAGES` flops and then a stability filter. The filtered level changes only after the synchronised level has differed from the filtered level for `FILTER_LEN` consecutive cycles. Any bounce restarts the filter count.
- **Decode.** The decoder keeps `prev = {A,B}` of the filtered levels.
  - Forward sequence is 00→10→11→01→00 (A leads B). Each forward step does `pos+1`.
  - Reverse is the opposite sequence. Each reverse step does `pos-1`.
  - No change leaves all state unchanged.
  - If both bits change in one cycle, the count is unchanged, `err` is set, and `prev` still updates.
- **Position wrap.**
  - `pos` counts 0..`COUNTS_PER_REV`-1.
  - Forward step from `COUNTS_PER_REV`-1: `pos` becomes 0 and `rev` increments.
  - Reverse step from 0: `pos` becomes `COUNTS_PER_REV`-1 and `rev` decrements.
  - `rev` is 16-bit two's complement and wraps silently (0x7FFF+1 → 0x8000).
- **Output width.** `pos` is zero-extended into bits [15:0]. When `COUNTS_PER_REV` = 65536, all 16 bits are used.
- **`clear`.** It zeroes `pos`, `rev` and `err` on the next edge. It has priority over any same-cycle step or index event. `prev` is not cleared.
- **Reset.** `angle_out` = 0 and `err` = 0. Filter outputs and `prev` reset to 0, and filter counters reset to 0. Reset asserted mid-step discards that step.
- **Startup.** If the pins sit at {A,B}=11 at reset release, the first filtered update changes `prev` from 00 to 11. This is a double-bit change, so `err` is set. Software issues `clear` after startup.

## Timing
- **Latency.** Suppose a pin edge is first captured at clock edge k and then held stable. `angle_out` reflects the resulting step at edge k + `SYNC_STAGES` + `FILTER_LEN` + 1. With the defaults this is k+7.
- **Register outputs.** `angle_out` and `err` come straight from registers, with no combinational path from the pins.
- **Step rate.** At most one step is counted per cycle. The maximum pin transition rate is one per `FILTER_LEN`+1 cycles. Faster input is filtered out and is not an error.
- **Clear timing.** `clear` sampled high at edge k gives `angle_out` = 0 and `err` = 0 after edge k.
- **Read coherence.** `angle_out` updates atomically in one register, so a PIO read never sees a torn `{rev,pos}` pair.

## Configuration
- `QUAD_INDEX_EN` defined:
  - The filtered `enc_i` rising edge sets `pos` to 0. `rev` is unchanged.
  - Any same-cycle A/B step is discarded. `clear` still has priority.
  - This index event adds one cycle beyond the A/B latency, for edge detection.
- `QUAD_INDEX_EN` undefined:
  - `enc_i` is ignored and no filter is instantiated for it.
  - Position only wraps at `COUNTS_PER_REV`.

## Structure
- Package `quad_enc_pkg` holds:
  - the output field widths (`POS_W` = 16, `REV_W` = 16);
  - the 2-bit phase encodings;
  - a `step_t` enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
- Sub-module `quad_input_filter` contains one synchroniser plus stability filter, parameterised by `SYNC_STAGES` and `FILTER_LEN`. It is instantiated for A and B, and for I when `QUAD_INDEX_EN` is defined.
- The top level holds the decode, the counters and the output register.

## Test plan
- **Reset and clean forward steps.** Hold reset, release, then apply `clear`. Apply 4 clean forward steps, each held 10 cycles. Required: `angle_out` = 0x0000_0004 and `err` = 0. Each update lands exactly `SYNC_STAGES`+`FILTER_LEN`+1 cycles after its pin edge.
- **Forward wrap.** Set `pos` = `COUNTS_PER_REV`-1 = 8191 and step forward once. Required: `angle_out` = 0x0001_0000. Step reverse once. Required: `angle_out` = 0x0000_1FFF.
- **Reverse wrap below zero.** From zero, apply 1 reverse step. Required: `angle_out` = 0xFFFF_1FFF (rev = -1).
- **Glitch rejection and illegal transition.**
  - A pulse on A lasting `FILTER_LEN`-1 cycles gives no count change.
  - A and B toggling simultaneously with a stable hold gives `err` = 1 and no count change.
  - A following `clear` gives `err` = 0.
- **Priority cases.** Assert `clear` in the same cycle as a filtered step. Required: `angle_out` = 0. With `QUAD_INDEX_EN` and `pos` = 100, raise the index. Required: `pos` = 0 and `rev` unchanged.
- **Reset mid-sequence.** Assert `reset` mid-sequence, between pin edge and count update. Required: outputs are 0 asynchronously and the pending step is lost.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// Shared widths, phase encodings and step classification for the quadrature angle encoder.
package quad_enc_pkg;

  localparam int POS_W = 16;
  localparam int REV_W = 16;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  // Phases are {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ERR;
    end else begin
      case (prev)
        PH_00:   s = (cur == PH_10) ? STEP_FWD : STEP_REV;
        PH_10:   s = (cur == PH_11) ? STEP_FWD : STEP_REV;
        PH_11:   s = (cur == PH_01) ? STEP_FWD : STEP_REV;
        default: s = (cur == PH_00) ? STEP_FWD : STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser chain plus stability filter for one asynchronous encoder pin.
module quad_input_filter
  import quad_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  // The filtered level follows only after the synchronised level has disagreed with it
  // on FILTER_LEN+1 consecutive edges; any agreement restarts the count.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN)) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/quad_angle_encoder.sv
// 4x quadrature decoder producing the {rev, pos} angle word for the PIO in_port.
// Define QUAD_INDEX_EN to let the filtered index rising edge zero the position.
module quad_angle_encoder
  import quad_enc_pkg::*;
#(
  parameter int COUNTS_PER_REV = 8192,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_i,
  input  logic        clear,
  output logic [31:0] angle_out,
  output logic        err
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

  logic             a_f, b_f;
  logic [1:0]       prev_q, prev_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             err_q, err_d;
  step_t            step;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .pin(enc_a), .level(a_f)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .pin(enc_b), .level(b_f)
  );

`ifdef QUAD_INDEX_EN
  logic i_f, i_dly_q, i_dly_d, idx_q, idx_d;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk(clk), .reset(reset), .pin(enc_i), .level(i_f)
  );

  assign i_dly_d = i_f;
  assign idx_d   = i_f & ~i_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_dly_q <= 1'b0;
      idx_q   <= 1'b0;
    end else begin
      i_dly_q <= i_dly_d;
      idx_q   <= idx_d;
    end
  end
`else
  logic unused_enc_i;
  assign unused_enc_i = enc_i;
`endif

  always_comb begin
    step   = decode_step(prev_q, {a_f, b_f});
    prev_d = {a_f, b_f};
    pos_d  = pos_q;
    rev_d  = rev_q;
    err_d  = err_q;
    case (step)
      STEP_FWD: begin
        if (pos_q == POS_MAX) begin
          pos_d = '0;
          rev_d = rev_q + 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      STEP_REV: begin
        if (pos_q == '0) begin
          pos_d = POS_MAX;
          rev_d = rev_q - 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
      STEP_ERR: err_d = 1'b1;
      default: ;
    endcase
`ifdef QUAD_INDEX_EN
    if (idx_q) begin
      pos_d = '0;
      rev_d = rev_q;
    end
`endif
    if (clear) begin
      pos_d = '0;
      rev_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= PH_00;
      pos_q  <= '0;
      rev_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pos_q  <= pos_d;
      rev_q  <= rev_d;
      err_q  <= err_d;
    end
  end

  // pos and rev load on the same edge, so a PIO read always sees a coherent pair.
  assign angle_out = {rev_q, pos_q};
  assign err       = err_q;

endmodule

// File: tb/tb_quad_angle_encoder.sv
// Directed scoreboard bench for quad_angle_encoder (default parameters).
module tb_quad_angle_encoder;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CPR  = 8192;
  localparam int LAT  = SYNC + FILT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_a, enc_b, enc_i, clear;
  logic [31:0] angle_out;
  logic        err;

  quad_angle_encoder #(.COUNTS_PER_REV(CPR), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
    .clear(clear), .angle_out(angle_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] angle;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  int          exp_pos;
  logic [15:0] exp_rev;
  logic        exp_err;
  logic [1:0]  cur_ab;
  logic [1:0]  fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    logic [1:0] r = 2'b00;
    for (int i = 0; i < 4; i++) if (fwd_seq[i] == ab) r = fwd_seq[(i + 1) % 4];
    return r;
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ab);
    logic [1:0] r = 2'b00;
    for (int i = 0; i < 4; i++) if (fwd_seq[i] == ab) r = fwd_seq[(i + 3) % 4];
    return r;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag   = tag;
    e.angle = {exp_rev, 16'(exp_pos)};
    e.err   = exp_err;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got angle_out=%h err=%b, required a queued expectation", angle_out, err);
    end else begin
      e = sb.pop_front();
      assert (angle_out === e.angle && err === e.err) else begin
        fails++;
        $error("FAIL %s: got angle_out=%h err=%b, required angle_out=%h err=%b",
               e.tag, angle_out, err, e.angle, e.err);
      end
    end
  endtask

  task automatic model_step(input logic [1:0] nab);
    if (nab == cur_ab) begin
    end else if (nab == next_fwd(cur_ab)) begin
      if (exp_pos == CPR - 1) begin
        exp_pos = 0;
        exp_rev = exp_rev + 16'd1;
      end else begin
        exp_pos = exp_pos + 1;
      end
    end else if (nab == next_rev(cur_ab)) begin
      if (exp_pos == 0) begin
        exp_pos = CPR - 1;
        exp_rev = exp_rev - 16'd1;
      end else begin
        exp_pos = exp_pos - 1;
      end
    end else begin
      exp_err = 1'b1;
    end
    cur_ab = nab;
  endtask

  task automatic drive(input logic [1:0] nab);
    @(posedge clk);
    #1;
    {enc_a, enc_b} = nab;
  endtask

  task automatic model_clear();
    exp_pos = 0;
    exp_rev = '0;
    exp_err = 1'b0;
  endtask

  task automatic step_and_check(input logic [1:0] nab, input string tag);
    model_step(nab);
    push_exp(tag);
    drive(nab);
    repeat (12) @(posedge clk);
    #1;
    pop_check();
  endtask

  // Checks the step is absent after LAT edges from the capturing edge and present after LAT+1.
  task automatic step_latency(input logic [1:0] nab, input string tag);
    push_exp({tag, "_before"});
    drive(nab);
    repeat (LAT) @(posedge clk);
    #1;
    pop_check();
    model_step(nab);
    push_exp({tag, "_after"});
    @(posedge clk);
    #1;
    pop_check();
    repeat (2) @(posedge clk);
  endtask

  task automatic quiet_step(input logic [1:0] nab);
    model_step(nab);
    drive(nab);
    repeat (5) @(posedge clk);
  endtask

  task automatic clear_check(input string tag);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    push_exp(tag);
    pop_check();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    enc_i = 1'b0;
    clear = 1'b0;
    cur_ab = 2'b00;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_state");
    pop_check();
    reset = 1'b0;
    clear_check("initial_clear");

    for (int i = 0; i < 4; i++) step_latency(next_fwd(cur_ab), $sformatf("fwd_step%0d", i));
    push_exp("four_forward");
    pop_check();

    clear_check("clear_before_rev_wrap");
    step_and_check(next_rev(cur_ab), "rev_wrap_below_zero");
    step_and_check(next_fwd(cur_ab), "fwd_back_to_zero");

    for (int i = 0; i < CPR - 1; i++) quiet_step(next_fwd(cur_ab));
    repeat (10) @(posedge clk);
    #1;
    push_exp("pos_at_max");
    pop_check();
    step_and_check(next_fwd(cur_ab), "fwd_wrap");
    step_and_check(next_rev(cur_ab), "rev_unwrap");

    push_exp("glitch_rejected");
    @(posedge clk);
    #1;
    enc_a = ~enc_a;
    repeat (FILT - 1) @(posedge clk);
    #1;
    enc_a = ~enc_a;
    repeat (15) @(posedge clk);
    #1;
    pop_check();

    step_and_check(cur_ab ^ 2'b11, "illegal_double");
    clear_check("clear_err");

    model_step(next_fwd(cur_ab));
    model_clear();
    push_exp("clear_beats_step");
    drive(cur_ab);
    repeat (LAT) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    pop_check();
    step_and_check(next_fwd(cur_ab), "step_after_clear_prio");

    drive(next_fwd(cur_ab));
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    cur_ab = 2'b00;
    model_clear();
    #1;
    push_exp("async_reset");
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    push_exp("pending_step_lost");
    pop_check();
    step_and_check(next_fwd(cur_ab), "step_after_reset");

`ifdef QUAD_INDEX_EN
    clear_check("clear_before_index");
    for (int i = 0; i < 100; i++) quiet_step(next_fwd(cur_ab));
    repeat (10) @(posedge clk);
    #1;
    push_exp("pos_100");
    pop_check();
    enc_i = 1'b1;
    exp_pos = 0;
    repeat (15) @(posedge clk);
    #1;
    push_exp("index_zero_pos");
    pop_check();
    enc_i = 1'b0;
    repeat (10) @(posedge clk);
    step_and_check(next_rev(cur_ab), "rev_before_index");
    #1;
    enc_i = 1'b1;
    exp_pos = 0;
    repeat (15) @(posedge clk);
    #1;
    push_exp("index_keeps_rev");
    pop_check();
    enc_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
